// File: rtl/seg7_score_decoder_if.sv
// Segment inputs and decoded score outputs of the seven-segment score reader.
// The decoder uses the slave view; whatever drives the segment lines uses the master view.
interface seg7_score_decoder_if;
  logic [6:0] seg_tens_i;
  logic [6:0] seg_ones_i;
  logic       clear_i;
  logic [3:0] tens_o;
  logic [3:0] ones_o;
  logic [6:0] score_o;
  logic       valid_o;
  logic       change_o;
  logic       err_o;

  modport master (
    output seg_tens_i, seg_ones_i, clear_i,
    input  tens_o, ones_o, score_o, valid_o, change_o, err_o
  );

  modport slave (
    input  seg_tens_i, seg_ones_i, clear_i,
    output tens_o, ones_o, score_o, valid_o, change_o, err_o
  );
endinterface

// File: rtl/seg7_score_decoder.sv
// Reads a two-digit seven-segment scoreboard and publishes the score once it is stable.
// The segments are synchronized and debounced, then decoded to BCD and binary.
module seg7_score_decoder #(
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                 clk_1khz_i,
  input  logic                 rst_n_i,
  seg7_score_decoder_if.slave  bus
);

  typedef enum logic [1:0] {SETTLE, CAPTURE, LOCKED} state_e;

  // Leaving SETTLE on the edge where the counter becomes STABLE_CYCLES-1 gives a
  // capture on edge STABLE_CYCLES+3 after the input change.
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 2);

  state_e      state_q, state_d;
  logic [13:0] sync1_q, sync1_d;
  logic [13:0] sync2_q, sync2_d;
  logic [13:0] prev_q, prev_d;
  logic [13:0] lock_q, lock_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [6:0]  score_q, score_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        change_q, change_d;

  logic        same;
  logic [7:0]  cnt_inc;
  logic [4:0]  tens_res;
  logic [4:0]  ones_res;
  logic        legal;
  logic [6:0]  score_new;

  // Returns {legal, bcd}; blank is legal only where leading-zero suppression applies.
  function automatic logic [4:0] decode_digit(input logic [6:0] pat, input logic blank_ok);
    case (pat)
      7'h3F:   return {1'b1, 4'd0};
      7'h06:   return {1'b1, 4'd1};
      7'h5B:   return {1'b1, 4'd2};
      7'h4F:   return {1'b1, 4'd3};
      7'h66:   return {1'b1, 4'd4};
      7'h6D:   return {1'b1, 4'd5};
      7'h7D:   return {1'b1, 4'd6};
      7'h07:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h6F:   return {1'b1, 4'd9};
      7'h00:   return {blank_ok, 4'd0};
      default: return 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    sync1_d   = {bus.seg_tens_i, bus.seg_ones_i};
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    lock_d    = lock_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    score_d   = score_q;
    valid_d   = valid_q;
    err_d     = err_q;
    change_d  = 1'b0;

    same      = (sync2_q == prev_q);
    cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    tens_res  = decode_digit(prev_q[13:7], 1'b1);
    ones_res  = decode_digit(prev_q[6:0], 1'b0);
    legal     = tens_res[4] & ones_res[4];
    score_new = ({3'b000, tens_res[3:0]} * 7'd10) + {3'b000, ones_res[3:0]};

    if (bus.clear_i) begin
      state_d = SETTLE;
      cnt_d   = '0;
      tens_d  = '0;
      ones_d  = '0;
      score_d = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (same) begin
            cnt_d = cnt_inc;
            if (cnt_q >= CNT_LAST) begin
              state_d = CAPTURE;
            end
          end else begin
            cnt_d = '0;
          end
        end
        CAPTURE: begin
          state_d = LOCKED;
          lock_d  = prev_q;
          if (legal) begin
            tens_d   = tens_res[3:0];
            ones_d   = ones_res[3:0];
            score_d  = score_new;
            valid_d  = 1'b1;
            change_d = (score_new != score_q) || !valid_q;
          end else begin
            err_d = 1'b1;
          end
        end
        LOCKED: begin
          // Compare against the captured pattern so a change landing on the capture cycle is not lost.
          if (sync2_q != lock_q) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1khz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= SETTLE;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      lock_q   <= '0;
      cnt_q    <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      score_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      lock_q   <= lock_d;
      cnt_q    <= cnt_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      score_q  <= score_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      change_q <= change_d;
    end
  end

  assign bus.tens_o   = tens_q;
  assign bus.ones_o   = ones_q;
  assign bus.score_o  = score_q;
  assign bus.valid_o  = valid_q;
  assign bus.err_o    = err_q;
  assign bus.change_o = change_q;

endmodule
